// File: rtl/risc_pkg.sv
// Shared RV32I constants: ALU control codes, major opcodes and the funct3 -> ALU op map.
// Used by the issue stage decoder and by the arithmetic logic unit.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package risc_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ctrl_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // alt selects SUB/SRA over ADD/SRL; callers decide whether alt is meaningful.
  function automatic alu_ctrl_t f3_ctrl(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_ctrl = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLT;
      3'b011:  f3_ctrl = ALU_SLTU;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I field decoder: ALU control code, final operands and illegal flag.
// No state, zero latency; illegal encodings collapse to ADD with zero operands.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module alu_op_decoder
  import risc_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] rs1_val,
  input  logic [WORD_SIZE-1:0] rs2_val,
  input  logic [WORD_SIZE-1:0] imm,
  output logic [3:0]           control,
  output logic [WORD_SIZE-1:0] in1,
  output logic [WORD_SIZE-1:0] in2,
  output logic                 illegal
);

  alu_ctrl_t ctrl;
  logic      alt;
  logic      f7_ok;
  logic      shift;
  logic      is_op;

  assign alt   = (funct7 == F7_ALT);
  assign f7_ok = (funct7 == F7_BASE) || alt;
  assign is_op = (opcode == OPC_OP);

  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    shift   = 1'b0;
    in1     = rs1_val;
    in2     = is_op ? rs2_val : imm;
    case (opcode)
      OPC_OP: begin
        shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
        illegal = !f7_ok || (alt && funct3 != 3'b000 && funct3 != 3'b101);
        ctrl    = f3_ctrl(funct3, alt);
      end
      OPC_OPIMM: begin
        shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
        illegal = (alt && funct3 != 3'b101) || (shift && !f7_ok);
        ctrl    = (funct3 == 3'b000) ? ALU_ADD : f3_ctrl(funct3, alt);
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: ctrl = ALU_ADD;
      OPC_LUI: begin
        ctrl = ALU_ADD;
        in1  = '0;
      end
      OPC_AUIPC: begin
        ctrl = ALU_ADD;
        in1  = pc;
      end
      default: illegal = 1'b1;
    endcase
    // Shift amount is only the low five bits of the operand.
    if (shift) in2 = {{(WORD_SIZE-5){1'b0}}, in2[4:0]};
    if (illegal) begin
      ctrl = ALU_ADD;
      in1  = '0;
      in2  = '0;
    end
  end

  assign control = ctrl;

endmodule

// File: rtl/alu_issue_stage.sv
// Decodes an instruction and queues it in a 2-entry skid FIFO toward execute; 1-cycle latency.
// in_ready is registered (occupancy < 2) and independent of out_ready; outputs hold while stalled.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module alu_issue_stage
  import risc_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_pc,
  input  logic [WORD_SIZE-1:0] in_rs1_val,
  input  logic [WORD_SIZE-1:0] in_rs2_val,
  input  logic [WORD_SIZE-1:0] in_imm,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [4:0]           in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_control,
  output logic [WORD_SIZE-1:0] out_in1,
  output logic [WORD_SIZE-1:0] out_in2,
  output logic [4:0]           out_rd,
  output logic                 out_illegal
);

  logic [3:0]           dec_control;
  logic [WORD_SIZE-1:0] dec_in1;
  logic [WORD_SIZE-1:0] dec_in2;
  logic                 dec_illegal;

  alu_op_decoder #(.WORD_SIZE(WORD_SIZE)) u_dec (
    .opcode  (in_opcode),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .pc      (in_pc),
    .rs1_val (in_rs1_val),
    .rs2_val (in_rs2_val),
    .imm     (in_imm),
    .control (dec_control),
    .in1     (dec_in1),
    .in2     (dec_in2),
    .illegal (dec_illegal)
  );

  logic [3:0]           ctrl_q [2];
  logic [WORD_SIZE-1:0] in1_q  [2];
  logic [WORD_SIZE-1:0] in2_q  [2];
  logic [4:0]           rd_q   [2];
  logic                 ill_q  [2];

  logic [1:0] count, count_nxt;
  logic       wr_ptr, rd_ptr;
  logic       accept, consume;

  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    case ({accept, consume})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ctrl_q[i] <= 4'd0;
        in1_q[i]  <= '0;
        in2_q[i]  <= '0;
        rd_q[i]   <= 5'd0;
        ill_q[i]  <= 1'b0;
      end
    end else if (flush) begin
      // Flush outranks any accept/consume in the same cycle.
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (accept) begin
        ctrl_q[wr_ptr] <= dec_control;
        in1_q[wr_ptr]  <= dec_in1;
        in2_q[wr_ptr]  <= dec_in2;
        rd_q[wr_ptr]   <= in_rd;
        ill_q[wr_ptr]  <= dec_illegal;
        wr_ptr         <= ~wr_ptr;
      end
      if (consume) rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      in_ready <= (count_nxt < 2'd2);
    end
  end

  assign out_control = ctrl_q[rd_ptr];
  assign out_in1     = in1_q[rd_ptr];
  assign out_in2     = in2_q[rd_ptr];
  assign out_rd      = rd_q[rd_ptr];
  assign out_illegal = ill_q[rd_ptr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid-buffer backpressure, flush and reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_control;
  logic [31:0] out_in1, out_in2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.WORD_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_control(out_control),
    .out_in1(out_in1), .out_in2(out_in2), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sequence did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd);
    in_valid   = 1'b1;
    in_opcode  = opc;
    in_funct3  = f3;
    in_funct7  = f7;
    in_pc      = pc;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
    in_imm     = imm;
    in_rd      = rd;
  endtask

  initial begin
    // Reset state, no clock edge needed
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_control", {28'd0, out_control}, 32'd0);
    chk("rst_in1", out_in1, 32'd0);
    chk("rst_in2", out_in2, 32'd0);
    chk("rst_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // SUB through an empty buffer, 1-cycle latency
    out_ready = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0100000, 32'h0, 32'd10, 32'd3, 32'h0, 5'd7);
    tick();
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_control", {28'd0, out_control}, 32'd1);
    chk("sub_in1", out_in1, 32'd10);
    chk("sub_in2", out_in2, 32'd3);
    chk("sub_rd", {27'd0, out_rd}, 32'd7);

    // SRAI then AUIPC back to back: accept and consume together
    drive(7'b0010011, 3'b101, 7'b0100000, 32'h0, 32'h8000_0000, 32'h0, 32'hFFFF_FC25, 5'd8);
    tick();
    chk("srai_control", {28'd0, out_control}, 32'd7);
    chk("srai_in2", out_in2, 32'd5);
    chk("srai_rd", {27'd0, out_rd}, 32'd8);
    drive(7'b0010111, 3'b000, 7'b0000000, 32'h100, 32'h55, 32'h66, 32'h2000, 5'd9);
    tick();
    chk("auipc_control", {28'd0, out_control}, 32'd0);
    chk("auipc_in1", out_in1, 32'h100);
    chk("auipc_in2", out_in2, 32'h2000);
    chk("auipc_in_ready", {31'd0, in_ready}, 32'd1);
    drive(7'b0110111, 3'b000, 7'b0000000, 32'h0, 32'h55, 32'h0, 32'h1234_5000, 5'd10);
    tick();
    chk("lui_in1", out_in1, 32'd0);
    chk("lui_in2", out_in2, 32'h1234_5000);
    drive(7'b0110011, 3'b001, 7'b0000000, 32'h0, 32'hF, 32'h0000_0123, 32'h0, 5'd11);
    tick();
    chk("sll_control", {28'd0, out_control}, 32'd5);
    chk("sll_in2", out_in2, 32'd3);
    drive(7'b0110011, 3'b011, 7'b0000000, 32'h0, 32'h1, 32'hFFFF_FF23, 32'h0, 5'd12);
    tick();
    chk("sltu_control", {28'd0, out_control}, 32'd9);
    chk("sltu_in2", out_in2, 32'hFFFF_FF23);
    drive(7'b0000011, 3'b010, 7'b0000000, 32'h0, 32'h400, 32'h0, 32'hFFFF_FFFC, 5'd13);
    tick();
    chk("load_control", {28'd0, out_control}, 32'd0);
    chk("load_in2", out_in2, 32'hFFFF_FFFC);
    drive(7'b0110011, 3'b000, 7'b0000001, 32'h0, 32'h1, 32'h2, 32'h0, 5'd14);
    tick();
    chk("op_bad_f7_illegal", {31'd0, out_illegal}, 32'd1);
    chk("op_bad_f7_in1", out_in1, 32'd0);
    drive(7'b0010011, 3'b000, 7'b0100000, 32'h0, 32'h1, 32'h2, 32'h0000_0400, 5'd15);
    tick();
    chk("addi_alt_illegal", {31'd0, out_illegal}, 32'd1);
    drive(7'b0110011, 3'b101, 7'b0100000, 32'h0, 32'h1, 32'h0000_0022, 32'h0, 5'd16);
    tick();
    chk("sra_illegal", {31'd0, out_illegal}, 32'd0);
    chk("sra_control", {28'd0, out_control}, 32'd7);
    chk("sra_in2", out_in2, 32'd2);
    in_valid = 1'b0;
    tick();
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: three offers, two accepted
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h1, 32'h1, 32'h0, 5'd1);
    tick();
    chk("bp_a_rd", {27'd0, out_rd}, 32'd1);
    chk("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
    drive(7'b0110011, 3'b110, 7'b0000000, 32'h0, 32'h2, 32'h2, 32'h0, 5'd2);
    tick();
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_rd", {27'd0, out_rd}, 32'd1);
    drive(7'b0110011, 3'b111, 7'b0000000, 32'h0, 32'h3, 32'h3, 32'h0, 5'd3);
    tick();
    chk("bp_c_hold_rd", {27'd0, out_rd}, 32'd1);
    chk("bp_c_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_b_rd", {27'd0, out_rd}, 32'd2);
    chk("bp_b_control", {28'd0, out_control}, 32'd3);
    chk("bp_reopen_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);

    // Illegal opcode between neighbours
    out_ready = 1'b0;
    drive(7'b0110011, 3'b100, 7'b0000000, 32'h0, 32'h4, 32'h4, 32'h0, 5'd4);
    tick();
    chk("ill_x_rd", {27'd0, out_rd}, 32'd4);
    chk("ill_x_illegal", {31'd0, out_illegal}, 32'd0);
    chk("ill_x_control", {28'd0, out_control}, 32'd2);
    drive(7'b1110011, 3'b000, 7'b0000000, 32'h9, 32'h9, 32'h9, 32'h9, 5'd5);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ill_rd", {27'd0, out_rd}, 32'd5);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_control", {28'd0, out_control}, 32'd0);
    chk("ill_in1", out_in1, 32'd0);
    chk("ill_in2", out_in2, 32'd0);
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h6, 32'h6, 32'h0, 5'd6);
    tick();
    chk("ill_y_rd", {27'd0, out_rd}, 32'd6);
    chk("ill_y_illegal", {31'd0, out_illegal}, 32'd0);
    in_valid = 1'b0;
    tick();

    // Flush with buffer full and an offered instruction
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h1, 32'h1, 32'h0, 5'd10);
    tick();
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h1, 32'h1, 32'h0, 5'd11);
    tick();
    chk("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h1, 32'h1, 32'h0, 5'd12);
    tick();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("fl_dropped_valid", {31'd0, out_valid}, 32'd0);
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h1, 32'h1, 32'h0, 5'd13);
    tick();
    chk("fl_next_valid", {31'd0, out_valid}, 32'd1);
    chk("fl_next_rd", {27'd0, out_rd}, 32'd13);

    // Asynchronous reset mid-stream
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_rd", {27'd0, out_rd}, 32'd0);
    #1;
    rst_n = 1'b1;
    drive(7'b0110011, 3'b000, 7'b0000000, 32'h0, 32'h7, 32'h8, 32'h0, 5'd14);
    tick();
    chk("arst_rise_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_rise_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("arst_first_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_first_rd", {27'd0, out_rd}, 32'd14);
    chk("arst_first_in2", out_in2, 32'd8);
    in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: WORD_SIZE, default `WORD_SIZE (32), datapath width.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Flush  input  1  synchronous discard of all buffered entries.
REQ-005 In_valid  input  1  upstream holds a decoded instruction.
REQ-006 In_ready  output  1  stage accepts the instruction this cycle; registered, not dependent on Out_ready.
REQ-007 In_pc / In_rs1_val / In_rs2_val / In_imm  input  WORD_SIZE each  PC, register operands, sign-extended immediate.
REQ-008 In_opcode  input  7, In_funct3  input  3, In_funct7  input  7, In_rd  input  5  RV32I instruction fields.
REQ-009 Out_valid  output  1  ALU operation presented.
REQ-010 Out_ready  input  1  execute stage consumes the operation this cycle.
REQ-011 Out_control  output  4  ALU control code; Out_in1 / Out_in2  output  WORD_SIZE  ALU operands; Out_rd  output  5; Out_illegal  output  1  unsupported encoding.

Function
REQ-012 Transfer occurs on a port when valid and ready are both high at a rising edge; the stage SHALL hold Out_* stable while Out_valid=1 and Out_ready=0.
REQ-013 Storage SHALL be a 2-entry FIFO skid buffer; In_ready = (occupancy < 2), registered.
REQ-014 Latency SHALL be 1 cycle: an instruction accepted into an empty buffer appears on Out_* the next cycle.
REQ-015 Simultaneous accept and consume SHALL keep occupancy unchanged and preserve order; full with Out_ready=1 SHALL raise In_ready next cycle.
REQ-016 Control codes: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
REQ-017 OP (0110011) funct3 map: 000 ADD, or SUB if funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7=0100000; 110 OR; 111 AND.
REQ-018 OP-IMM (0010011) uses the same map except funct3=000 is always ADD.
REQ-019 LOAD (0000011), STORE (0100011), JALR (1100111), LUI (0110111), AUIPC (0010111) SHALL produce ADD.
REQ-020 Out_in1: In_pc for AUIPC, 0 for LUI, In_rs1_val otherwise; Out_in2: In_rs2_val for OP, In_imm otherwise.
REQ-021 For any shift, Out_in2 SHALL be the 5-bit shift amount zero-extended (bits [WORD_SIZE-1:5] cleared).
REQ-022 Illegal: unlisted opcode; OP funct7 not 0000000/0100000; funct7=0100000 with funct3 not 000/101 (OP) or not 101 (OP-IMM); OP-IMM shift with funct7 not 0000000/0100000.
REQ-023 Illegal entries SHALL still be passed downstream in order with Out_illegal=1, Out_control=ADD, Out_in1=Out_in2=0.
REQ-024 Flush SHALL empty the buffer at the edge; an instruction offered in the Flush cycle SHALL be dropped; Out_valid=0 and In_ready=1 the following cycle.
REQ-025 Flush has priority over simultaneous accept and consume.

Reset
REQ-026 Rst_n low SHALL immediately clear occupancy and force Out_valid=0, In_ready=0, Out_illegal=0, Out_control=0, Out_in1=Out_in2=0, Out_rd=0.
REQ-027 In_ready SHALL rise on the first rising edge after Rst_n deasserts; reset mid-transfer discards all entries.

Structure
REQ-028 ALU control codes and opcode constants SHALL live in the shared package risc_pkg, used also by arithmetic logic unit.
REQ-029 Decode SHALL be a combinational sub-module alu_op_decoder (fields -> control, operand selects, illegal); alu_issue_stage contains buffer, pointers and handshake only.
REQ-030 Decoding SHALL occur before storage; buffer entries hold decoded control, operands, rd, illegal.

Verification
REQ-031 OP funct3=000 funct7=0100000, rs1=10, rs2=3, Out_ready=1 -> next cycle Out_valid=1, control=1, in1=10, in2=3.
REQ-032 OP-IMM funct3=101 funct7=0100000, imm=0xFFFF_FC25 -> control=7, in2=5; AUIPC pc=0x100 imm=0x2000 -> control=0, in1=0x100.
REQ-033 Out_ready=0, three back-to-back valid instructions -> two accepted, In_ready=0; Out_ready=1 -> drained in order, In_ready=1 after one consume.
REQ-034 Opcode 1110011 -> Out_illegal=1, control=0, operands 0, order preserved relative to neighbours.
REQ-035 Buffer full, Flush=1 with In_valid=1 -> next cycle Out_valid=0, In_ready=1, dropped instruction never appears.
REQ-036 Rst_n pulsed low mid-stream, no clock edge -> Out_valid=0 immediately; first post-reset instruction has 1-cycle latency.
